result_fifo_reader: RTL and testbench
=====================================

# result_fifo_reader

Buffers readback words produced by the pulse sequencer (DDS readback, SPI results, loopback data) and hands them to the processor bus through a valid/ready read port. It sits at the consuming end of the sequencer's result-write protocol: one word per rising edge of the write request. It tracks occupancy and latches a sticky overflow when the sequencer outruns software.

## Interface

Parameters:
- RESULT_WIDTH, 32, width of each result word and bus beat
- DEPTH_LOG2, 4, log2 of the entry count (default 16 entries)

Ports:
- clock  input  1  single clock; all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- init  input  1  synchronous flush; same meaning as the sequencer's init
- result_data  input  RESULT_WIDTH  result word, valid in the first cycle result_WrReq is high
- result_WrReq  input  1  write request; one word per rising edge
- bus_rd_data  output  RESULT_WIDTH  current head beat; 0 when bus_rd_valid=0
- bus_rd_valid  output  1  head beat available
- bus_rd_ready  input  1  bus accepts beat
- fifo_level  output  DEPTH_LOG2+1  stored entries, 0..2^DEPTH_LOG2
- fifo_empty  output  1  fifo_level==0
- fifo_full  output  1  fifo_level==2^DEPTH_LOG2
- overflow  output  1  sticky; a word was dropped

## Operation

- Edge detect: register wr_req_d <= result_WrReq. push = result_WrReq & ~wr_req_d. result_data is sampled on the same clock edge that sees push.
- Holding result_WrReq high produces exactly one push. Re-arming requires at least one low cycle.
- Storage: circular buffer of 2^DEPTH_LOG2 entries. wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap modulo depth. fifo_level is a separate counter.
- Beat transfer: bus_rd_valid & bus_rd_ready on a clock edge. The final beat of an entry pops it.
- Push and pop in the same cycle: both take effect and fifo_level is unchanged. This applies when full (the word is accepted) and when level is 1.
- Push when full with no pop that cycle: the word is dropped, pointers and level are unchanged, and overflow <= 1.
- overflow clears only on resetn or init.
- init, synchronous, takes priority over push and pop in the same cycle:
  - pointers, fifo_level, overflow and the beat phase clear;
  - wr_req_d <= result_WrReq, so a request level held across init is not counted.
- Reset values:
  - bus_rd_valid=0, bus_rd_data=0, fifo_level=0, fifo_empty=1, fifo_full=0, overflow=0;
  - wr_req_d=0, so a request already high when resetn rises counts as one push.
- Memory contents are not reset.

## Timing

- Push-to-valid latency: 1 cycle. A word pushed at edge N into an empty FIFO gives bus_rd_valid=1 after edge N.
- bus_rd_valid = ~fifo_empty. bus_rd_data is read asynchronously from the head entry (distributed RAM).
- While valid and not ready, bus_rd_data and bus_rd_valid hold stable.
- Back-to-back beats are sustainable with ready held high: one beat per cycle.
- Minimum push spacing is 2 cycles (high, low) due to edge detection. Input throughput is 1 word per 2 cycles.
- The fifo_level, fifo_full, fifo_empty and overflow flags update on the edge following the event.

## Configuration

- RESULT_FIFO_TIMESTAMP_EN defined:
  - a RESULT_WIDTH-bit free-running cycle counter runs from 0 after reset or init, increments every cycle and wraps;
  - each push stores {counter value at the push edge, result_data};
  - each entry is read as two beats: data first, then timestamp;
  - a phase bit selects the beat; the entry pops on the timestamp beat handshake;
  - fifo_level counts entries, not beats;
  - init mid-entry resets the phase to data.
- Not defined: no counter and no phase bit; one beat per entry.

## Test plan

- Single push: after reset, pulse result_WrReq one cycle with result_data=0xDEADBEEF and ready=0.
  - Next cycle: valid=1, data=0xDEADBEEF, level=1.
  - Raise ready: one beat, then valid=0 and level=0.
- Held request: result_WrReq high 10 cycles with data 0x11 -> exactly one entry (level=1).
- Fill and overflow (DEPTH_LOG2=4): 17 pushes of 0..16 with ready=0.
  - After these: level=16, full=1, overflow=1.
  - Drain reads 0..15 in order; 16 is never seen.
- Full push+pop: with 16 entries, a push of 0xAA coincides with a beat handshake.
  - level stays 16, overflow stays 0;
  - 0xAA is read last.
- init mid-operation: with 5 entries, assert init for 1 cycle while result_WrReq is held high.
  - Next cycle: level=0, valid=0, overflow=0.
  - No push until result_WrReq falls and rises again.
- With RESULT_FIFO_TIMESTAMP_EN: pushes at cycles 3 and 8 after init with data 0x1 and 0x2.
  - Beats read: 0x1, 3, 0x2, 8.
  - level decrements only after the 2nd and 4th beats.

Source files
------------

// File: rtl/result_fifo_reader_if.sv
// Processor-bus read port of the result FIFO: valid/ready beat handshake.
// master = FIFO side (drives data/valid), slave = bus side (drives ready).
interface result_fifo_reader_if #(
  parameter int RESULT_WIDTH = 32
);
  logic [RESULT_WIDTH-1:0] bus_rd_data;
  logic                    bus_rd_valid;
  logic                    bus_rd_ready;

  modport master (output bus_rd_data, output bus_rd_valid, input bus_rd_ready);
  modport slave  (input bus_rd_data, input bus_rd_valid, output bus_rd_ready);
endinterface

// File: rtl/result_fifo_reader.sv
// result_fifo_reader: buffers sequencer readback words (one per rising edge of
// result_WrReq) and presents them on a valid/ready bus read port.
// Sticky overflow flags a word dropped because the FIFO was full.
// Optional feature macro: RESULT_FIFO_TIMESTAMP_EN -- each entry also stores
// a free-running cycle count and is read as two beats (data, then timestamp).
module result_fifo_reader #(
  parameter int RESULT_WIDTH = 32,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    init,
  input  logic [RESULT_WIDTH-1:0] result_data,
  input  logic                    result_WrReq,
  result_fifo_reader_if.master    bus,
  output logic [DEPTH_LOG2:0]     fifo_level,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic                    overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
`ifdef RESULT_FIFO_TIMESTAMP_EN
  localparam int ENTRY_W = 2 * RESULT_WIDTH;
`else
  localparam int ENTRY_W = RESULT_WIDTH;
`endif

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  wr_req_d;
  logic                  push, beat, pop, accept;
  logic [ENTRY_W-1:0]    wr_entry, head;

  assign push       = result_WrReq & ~wr_req_d;
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == FULL_LVL);
  assign bus.bus_rd_valid = ~fifo_empty;
  assign beat       = bus.bus_rd_valid & bus.bus_rd_ready;
  // A full FIFO still takes a word when the head pops on the same edge.
  assign accept     = push & (~fifo_full | pop);
  assign head       = mem[rd_ptr];

`ifdef RESULT_FIFO_TIMESTAMP_EN
  logic [RESULT_WIDTH-1:0] ts_cnt;
  logic                    phase;   // 0: data beat, 1: timestamp beat

  assign pop      = beat & phase;
  assign wr_entry = {ts_cnt, result_data};
  assign bus.bus_rd_data = !bus.bus_rd_valid ? '0 :
                           phase ? head[ENTRY_W-1:RESULT_WIDTH] : head[RESULT_WIDTH-1:0];

  // Free-running timestamp and beat phase; both restart on init.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ts_cnt <= '0;
      phase  <= 1'b0;
    end else if (init) begin
      ts_cnt <= '0;
      phase  <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (beat) phase <= ~phase;
    end
  end
`else
  assign pop      = beat;
  assign wr_entry = result_data;
  assign bus.bus_rd_data = bus.bus_rd_valid ? head : '0;
`endif

  // Storage write; contents are never reset, init suppresses the write.
  always_ff @(posedge clock) begin
    if (accept && !init) mem[wr_ptr] <= wr_entry;
  end

  // Edge detect, pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_req_d   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else if (init) begin
      // Sample the request level so a request held across init is not a push.
      wr_req_d   <= result_WrReq;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_req_d <= result_WrReq;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (!accept && pop) fifo_level <= fifo_level - 1'b1;
      if (push && !accept) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_result_fifo_reader.sv
// Directed bench for result_fifo_reader (default depth 16, 32-bit words).
// With RESULT_FIFO_TIMESTAMP_EN defined, the two-beat timestamp sequence is run
// instead of the single-beat scenarios.
module tb_result_fifo_reader;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        init = 1'b0;
  logic [31:0] result_data = '0;
  logic        result_WrReq = 1'b0;
  logic [4:0]  fifo_level;
  logic        fifo_empty, fifo_full, overflow;
  int          vectors = 0;
  int          miscompares = 0;

  result_fifo_reader_if #(.RESULT_WIDTH(32)) bus_if ();

  result_fifo_reader #(.RESULT_WIDTH(32), .DEPTH_LOG2(4)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .init         (init),
    .result_data  (result_data),
    .result_WrReq (result_WrReq),
    .bus          (bus_if.master),
    .fifo_level   (fifo_level),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One push: request high for one cycle, then low for one cycle.
  task automatic push_word(input logic [31:0] d);
    result_data  = d;
    result_WrReq = 1'b1;
    tick();
    result_WrReq = 1'b0;
    tick();
  endtask

  initial begin
    bus_if.bus_rd_ready = 1'b0;
    tick();
    chk("rst_valid",    bus_if.bus_rd_valid, 0);
    chk("rst_data",     bus_if.bus_rd_data, 0);
    chk("rst_level",    fifo_level, 0);
    chk("rst_empty",    fifo_empty, 1);
    chk("rst_full",     fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    resetn = 1'b1;
    tick();

`ifdef RESULT_FIFO_TIMESTAMP_EN
    init = 1'b1; tick(); init = 1'b0;      // counter 0 after this edge
    tick(); tick(); tick();                // counter 3
    result_data = 32'h1; result_WrReq = 1'b1; tick();   // stamped 3
    result_WrReq = 1'b0;
    tick(); tick(); tick(); tick();        // counter 8
    result_data = 32'h2; result_WrReq = 1'b1; tick();   // stamped 8
    result_WrReq = 1'b0;
    chk("ts_level0", fifo_level, 2);
    bus_if.bus_rd_ready = 1'b1;
    chk("ts_b0", bus_if.bus_rd_data, 32'h1); tick();
    chk("ts_lvl_b0", fifo_level, 2);
    chk("ts_b1", bus_if.bus_rd_data, 3);     tick();
    chk("ts_lvl_b1", fifo_level, 1);
    chk("ts_b2", bus_if.bus_rd_data, 32'h2); tick();
    chk("ts_lvl_b2", fifo_level, 1);
    chk("ts_b3", bus_if.bus_rd_data, 8);     tick();
    chk("ts_lvl_b3", fifo_level, 0);
    bus_if.bus_rd_ready = 1'b0;
`else
    // Single push with ready low, then one beat.
    result_data = 32'hDEADBEEF; result_WrReq = 1'b1; tick();
    result_WrReq = 1'b0;
    chk("sp_valid", bus_if.bus_rd_valid, 1);
    chk("sp_data",  bus_if.bus_rd_data, 32'hDEADBEEF);
    chk("sp_level", fifo_level, 1);
    tick();
    chk("sp_hold",  bus_if.bus_rd_data, 32'hDEADBEEF);
    bus_if.bus_rd_ready = 1'b1; tick(); bus_if.bus_rd_ready = 1'b0;
    chk("sp_valid_after", bus_if.bus_rd_valid, 0);
    chk("sp_level_after", fifo_level, 0);
    chk("sp_data_after",  bus_if.bus_rd_data, 0);

    // Held request counts once.
    result_data = 32'h11; result_WrReq = 1'b1;
    repeat (10) tick();
    result_WrReq = 1'b0; tick();
    chk("held_level", fifo_level, 1);
    chk("held_data",  bus_if.bus_rd_data, 32'h11);
    bus_if.bus_rd_ready = 1'b1; tick(); bus_if.bus_rd_ready = 1'b0;
    chk("held_drained", fifo_level, 0);

    // Fill with 17 words: last one dropped.
    for (int i = 0; i < 17; i++) push_word(32'(i));
    chk("fill_level", fifo_level, 16);
    chk("fill_full",  fifo_full, 1);
    chk("fill_ovf",   overflow, 1);
    bus_if.bus_rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), bus_if.bus_rd_data, 32'(i));
      tick();
    end
    bus_if.bus_rd_ready = 1'b0;
    chk("drain_empty", fifo_empty, 1);
    chk("drain_ovf_sticky", overflow, 1);

    // init clears overflow.
    init = 1'b1; tick(); init = 1'b0;
    chk("init_ovf_clr", overflow, 0);

    // Push coinciding with a pop while full is accepted.
    for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i));
    chk("fpp_full_before", fifo_full, 1);
    result_data = 32'hAA; result_WrReq = 1'b1; bus_if.bus_rd_ready = 1'b1;
    tick();
    result_WrReq = 1'b0; bus_if.bus_rd_ready = 1'b0;
    chk("fpp_level", fifo_level, 16);
    chk("fpp_ovf",   overflow, 0);
    bus_if.bus_rd_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("fpp_rd_%0d", i), bus_if.bus_rd_data, 32'h100 + 32'(i));
      tick();
    end
    chk("fpp_last", bus_if.bus_rd_data, 32'hAA);
    tick();
    bus_if.bus_rd_ready = 1'b0;
    chk("fpp_empty", fifo_empty, 1);

    // init with 5 entries while the request is held high.
    for (int i = 0; i < 4; i++) push_word(32'h50 + 32'(i));
    result_data = 32'h54; result_WrReq = 1'b1; tick();
    chk("init_pre_level", fifo_level, 5);
    init = 1'b1; tick(); init = 1'b0;
    chk("init_level", fifo_level, 0);
    chk("init_valid", bus_if.bus_rd_valid, 0);
    chk("init_ovf",   overflow, 0);
    repeat (3) tick();
    chk("init_no_push", fifo_level, 0);
    result_WrReq = 1'b0; tick();
    result_data = 32'h77; result_WrReq = 1'b1; tick();
    result_WrReq = 1'b0;
    chk("init_rearm_level", fifo_level, 1);
    chk("init_rearm_data",  bus_if.bus_rd_data, 32'h77);

    // Request already high when reset releases counts as one push.
    resetn = 1'b0; result_data = 32'h55; result_WrReq = 1'b1;
    tick();
    chk("rst2_level", fifo_level, 0);
    resetn = 1'b1; tick();
    result_WrReq = 1'b0;
    chk("rst2_push_level", fifo_level, 1);
    chk("rst2_push_data",  bus_if.bus_rd_data, 32'h55);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
